// File: rtl/s3_switch_debouncer.sv
// ---------------------------------------------------------------------------
// s3_switch_debouncer
//
// Conditions the raw slide-switch / push-button pins of the Spartan-3 board.
// Each bit is synchronised into clk with two flops, then filtered: a new level
// is accepted only after it has been seen for STABLE_CYCLES consecutive
// cycles. Accepting a new level produces a one-cycle rise or fall strobe.
//
// Ports:
//   clk     : system clock, all state on its rising edge
//   rst     : asynchronous, active-high reset
//   sw      : raw board pins, asynchronous to clk
//   sw_db   : debounced level per bit (registered)
//   rise    : one-cycle strobe per bit when sw_db goes 0->1 (registered)
//   fall    : one-cycle strobe per bit when sw_db goes 1->0 (registered)
//   changed : OR of all rise and fall bits, same cycle (registered)
// ---------------------------------------------------------------------------
module s3_switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Terminal count: the cycle on which a differing level has persisted long
    // enough. The counter never goes beyond this, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [CNT_W-1:0] cnt_r     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] db_nxt_s;
    logic [WIDTH-1:0] rise_nxt_s;
    logic [WIDTH-1:0] fall_nxt_s;
    logic             changed_nxt_s;

    // Two-flop synchroniser; s2_r is the only consumer-visible copy of sw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= sw;
            s2_r <= s1_r;
        end
    end

    // Per-bit stability filter: count cycles where the synchronised level
    // differs from the accepted one; any agreeing cycle restarts the count.
    always_comb begin
        db_nxt_s   = sw_db;
        rise_nxt_s = {WIDTH{1'b0}};
        fall_nxt_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (s2_r[i] == sw_db[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] >= CNT_MAX) begin
                // Level has held for the full period: accept it and strobe.
                cnt_nxt_s[i]  = {CNT_W{1'b0}};
                db_nxt_s[i]   = s2_r[i];
                rise_nxt_s[i] = s2_r[i];
                fall_nxt_s[i] = ~s2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
        changed_nxt_s = |(rise_nxt_s | fall_nxt_s);
    end

    // Counter and output registers; reset discards any pending transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            sw_db   <= {WIDTH{1'b0}};
            rise    <= {WIDTH{1'b0}};
            fall    <= {WIDTH{1'b0}};
            changed <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            sw_db   <= db_nxt_s;
            rise    <= rise_nxt_s;
            fall    <= fall_nxt_s;
            changed <= changed_nxt_s;
        end
    end

endmodule

// File: tb/tb_s3_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_s3_switch_debouncer
//
// Directed scenarios followed by a randomised phase. Inputs change on the
// falling edge; outputs are compared on the falling edge against a reference
// that keeps the history of pin samples and accepts a level when the last
// STABLE_CYCLES values seen by the filter all differ from the accepted level.
// ---------------------------------------------------------------------------
module tb_s3_switch_debouncer;

    localparam int W  = 8;
    localparam int SC = 4;
    localparam int CW = 3;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw;
    logic [W-1:0] sw_db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int tests_run;
    int tests_failed;

    // Reference state
    logic [W-1:0] hist_q [$];   // pin value sampled at each edge since release
    logic [W-1:0] seen_q [$];   // value presented to the filter at each edge
    logic [W-1:0] m_db;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         m_changed;

    s3_switch_debouncer #(
        .WIDTH(W),
        .STABLE_CYCLES(SC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .sw_db(sw_db),
        .rise(rise),
        .fall(fall),
        .changed(changed)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference update for one rising edge.
    task automatic model_edge();
        logic [W-1:0] s;
        logic [W-1:0] v;
        logic         want;
        bit           ok;
        if (rst) begin
            hist_q.delete();
            seen_q.delete();
            for (int i = 0; i < SC; i++) seen_q.push_back({W{1'b0}});
            m_db      = {W{1'b0}};
            m_rise    = {W{1'b0}};
            m_fall    = {W{1'b0}};
            m_changed = 1'b0;
        end else begin
            hist_q.push_back(sw);
            // The filter sees the pin as sampled two edges earlier.
            s = (hist_q.size() >= 3) ? hist_q[hist_q.size()-3] : {W{1'b0}};
            seen_q.push_back(s);
            m_rise = {W{1'b0}};
            m_fall = {W{1'b0}};
            for (int b = 0; b < W; b++) begin
                want = ~m_db[b];
                ok   = 1'b1;
                for (int j = 0; j < SC; j++) begin
                    v = seen_q[seen_q.size()-1-j];
                    if (v[b] != want) ok = 1'b0;
                end
                if (ok) begin
                    m_db[b] = want;
                    if (want) m_rise[b] = 1'b1;
                    else      m_fall[b] = 1'b1;
                end
            end
            m_changed = |(m_rise | m_fall);
        end
    endtask

    // One clock cycle: update the reference on the rising edge, compare on
    // the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("sw_db",   {24'd0, sw_db}, {24'd0, m_db});
        check_eq("rise",    {24'd0, rise},  {24'd0, m_rise});
        check_eq("fall",    {24'd0, fall},  {24'd0, m_fall});
        check_eq("changed", {31'd0, changed}, {31'd0, m_changed});
        check_eq("excl",    {24'd0, rise & fall}, 32'd0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_db         = {W{1'b0}};
        m_rise       = {W{1'b0}};
        m_fall       = {W{1'b0}};
        m_changed    = 1'b0;
        rst          = 1'b1;
        sw           = 8'hFF;

        // 1. Reset with all pins high, then release.
        hold(3);
        check_eq("t1_rst_db", {24'd0, sw_db}, 32'd0);
        rst = 1'b0;
        hold(5);
        check_eq("t1_pre_db", {24'd0, sw_db}, 32'd0);
        step();
        check_eq("t1_db",   {24'd0, sw_db}, 32'h0000_00FF);
        check_eq("t1_rise", {24'd0, rise},  32'h0000_00FF);
        check_eq("t1_chg",  {31'd0, changed}, 32'd1);
        step();
        check_eq("t1_rise_end", {24'd0, rise}, 32'd0);
        sw = 8'h00;
        hold(10);

        // 2. Clean press on bit 7.
        sw[7] = 1'b1;
        hold(5);
        check_eq("t2_pre_db7", {31'd0, sw_db[7]}, 32'd0);
        step();
        check_eq("t2_db",   {24'd0, sw_db}, 32'h0000_0080);
        check_eq("t2_rise", {24'd0, rise},  32'h0000_0080);
        hold(8);

        // 3. Bounce on bit 6: 1,0,1,0 for 3 cycles each, then hold 1.
        for (int k = 0; k < 4; k++) begin
            sw[6] = ~k[0];
            hold(3);
        end
        sw[6] = 1'b1;
        hold(5);
        check_eq("t3_pre_db6", {31'd0, sw_db[6]}, 32'd0);
        step();
        check_eq("t3_rise", {24'd0, rise}, 32'h0000_0040);
        hold(8);

        // 4. Three-cycle glitch on bit 0 must be ignored.
        sw[0] = 1'b1;
        hold(3);
        sw[0] = 1'b0;
        hold(10);
        check_eq("t4_db0", {31'd0, sw_db[0]}, 32'd0);

        // 5. Simultaneous rise on bit 7 and fall on bit 6.
        sw[7] = 1'b0;
        hold(10);
        sw[7] = 1'b1;
        sw[6] = 1'b0;
        hold(5);
        step();
        check_eq("t5_rise", {24'd0, rise}, 32'h0000_0080);
        check_eq("t5_fall", {24'd0, fall}, 32'h0000_0040);
        check_eq("t5_chg",  {31'd0, changed}, 32'd1);
        step();
        check_eq("t5_chg_end", {31'd0, changed}, 32'd0);
        hold(4);

        // 6. Reset in the middle of qualifying a press on bit 3.
        sw[3] = 1'b1;
        hold(3);
        rst = 1'b1;
        hold(2);
        check_eq("t6_rst_rise3", {31'd0, rise[3]}, 32'd0);
        rst = 1'b0;
        hold(5);
        check_eq("t6_pre_rise3", {31'd0, rise[3]}, 32'd0);
        step();
        check_eq("t6_rise3", {31'd0, rise[3]}, 32'd1);
        hold(6);

        // Randomised phase: sparse toggles give both glitches and stable runs;
        // occasional resets interrupt pending transitions.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) sw[b] = ~sw[b];
            end
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/s3_switch_debouncer.md
Name: s3_switch_debouncer

Overview:
- Input-side conditioner for the Spartan-3 board's slide switches and push buttons. It is the reader of the raw `sw` pins that feed logic-gate exercises such as the `Led`-driving gate wrappers.
- Per bit, it synchronizes the asynchronous pin into `clk`, filters contact bounce with a stability counter, and produces a clean level plus one-cycle rise and fall strobes.
- Sits between board pins and any downstream logic.

Parameters:
- WIDTH, 8: number of independent switch/button inputs.
- STABLE_CYCLES, 500000: consecutive cycles a new level must persist before it is accepted (10 ms at 50 MHz). Legal range 1 .. 2^CNT_W.
- CNT_W, 19: width of each per-bit stability counter.

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sw  input  WIDTH  raw board pins, asynchronous to clk.
- sw_db  output  WIDTH  debounced level per bit.
- rise  output  WIDTH  one-cycle strobe per bit when sw_db goes 0->1.
- fall  output  WIDTH  one-cycle strobe per bit when sw_db goes 1->0.
- changed  output  1  OR of all rise and fall bits, in the same cycle.

Behaviour:
- Reset (async assert, sync release):
  - Both synchronizer stages cleared to 0.
  - All counters cleared to 0.
  - sw_db, rise, fall and changed cleared to 0.
  - A pin held high through reset is therefore reported as a rise one debounce period after release; this is intended.
- Synchronizer: two flops per bit, s1 <= sw and s2 <= s1. s2 is the only use of sw. There is no combinational path from sw to any output.
- Per-bit filter, evaluated each clk edge:
  - If s2 == sw_db: cnt <= 0; rise and fall for that bit are 0.
  - If s2 != sw_db and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - If s2 != sw_db and cnt == STABLE_CYCLES-1: sw_db <= s2; cnt <= 0; set rise if s2 = 1, otherwise set fall.
- Strobes are registered. rise/fall are high for exactly one cycle, the first cycle sw_db shows the new value.
- Latency:
  - A clean pin edge before clk edge N reaches s2 after edge N+1.
  - sw_db updates at edge N+1+STABLE_CYCLES, so sw_db is visible STABLE_CYCLES+2 cycles after the pin changes.
- Bounce: any cycle with s2 == sw_db clears cnt. A glitch shorter than STABLE_CYCLES consecutive cycles never changes sw_db and never produces a strobe.
- Independence:
  - Bits share no state.
  - Several bits may strobe in the same cycle.
  - changed is asserted once for that cycle regardless of how many bits strobe.
- STABLE_CYCLES = 1: sw_db follows s2 with one cycle delay and strobes on every s2 change.
- Counter never wraps: it is bounded by STABLE_CYCLES-1 <= 2^CNT_W-1.
- Reset mid-count: counter and outputs clear immediately. A pending transition is discarded and must re-qualify for a full period after release.
- rise and fall for one bit are mutually exclusive in every cycle.

Test Plan (STABLE_CYCLES=4, CNT_W=3, WIDTH=8):
1. Reset behaviour: rst=1 with sw=8'hFF, then release.
   - All outputs must be 0 while in reset.
   - sw_db = 8'hFF exactly 6 cycles after sw is sampled post-release.
   - rise = 8'hFF and changed = 1 for exactly one cycle, then rise = 0.
2. Clean press: sw[7] 0->1, held.
   - sw_db[7] = 1 on edge 6 after the change.
   - rise[7] pulses 1 cycle; fall = 0; other sw_db bits unchanged.
3. Bounce: sw[6] toggles 1,0,1,0,1 with 3 cycles per level, then holds 1.
   - No strobe during the toggling.
   - Single rise[6] exactly 6 cycles after the final 0->1.
4. Glitch rejection: sw[0] high for 3 cycles, then low, with sw_db[0] = 0.
   - sw_db[0] stays 0; rise[0] and changed never assert.
5. Simultaneous events: sw[7] 0->1 and sw[6] 1->0 in the same cycle.
   - In the same cycle: rise = 8'h80, fall = 8'h40, changed = 1 for one cycle.
6. Reset mid-count: start a 0->1 on sw[3] and assert rst after 3 cycles; release with sw[3] still 1.
   - No rise[3] before or during reset.
   - rise[3] arrives a full 6 cycles after release.
